// File: rtl/icache_mem_responder.sv
// Instruction-fetch responder: accepts fetch pcs, issues line reads to an in-order memory port
// and returns {pc, line}, with credit-limited outstanding work and flush-driven response dropping.
package len5_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ICACHE_LINE_W = 128;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [ICACHE_LINE_W-1:0] line;
  } icache_out_t;
endpackage

module icache_mem_responder #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned XLEN   = len5_pkg::XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       addr_i,
  input  logic                  addr_valid_i,
  output logic                  addr_ready_o,
  output len5_pkg::icache_out_t data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  mem_req_o,
  output logic [XLEN-1:0]       mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [LINE_W-1:0]     mem_rdata_i
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = CntW + 2;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OffW = $clog2(LINE_W / 8);

  logic [XLEN-1:0]   pc_mem_q   [DEPTH];
  logic [XLEN-1:0]   resp_pc_q  [DEPTH];
  logic [LINE_W-1:0] resp_line_q[DEPTH];

  logic [PtrW-1:0] pc_wr_q, pc_wr_d, pc_rd_q, pc_rd_d;
  logic [PtrW-1:0] rs_wr_q, rs_wr_d, rs_rd_q, rs_rd_d;
  logic [CntW-1:0] inflight_q, inflight_d, buffered_q, buffered_d, drop_cnt_q, drop_cnt_d;

  logic [SumW-1:0] total;
  logic            credit, pc_push, pc_pop, rs_push, rs_pop, drop_hit, rvalid_known;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign total = SumW'(inflight_q) + SumW'(buffered_q) + SumW'(drop_cnt_q);
  assign credit = total < SumW'(DEPTH);

  assign mem_req_o    = addr_valid_i & credit & ~flush_i & ~rst_i;
  assign mem_addr_o   = {addr_i[XLEN-1:OffW], {OffW{1'b0}}};
  assign addr_ready_o = mem_req_o & mem_gnt_i;

  // Stale responses are consumed first; an rvalid with nothing outstanding is ignored.
  assign rvalid_known = mem_rvalid_i & ((drop_cnt_q != '0) | (inflight_q != '0));
  assign drop_hit     = mem_rvalid_i & (drop_cnt_q != '0);
  assign pc_push      = addr_ready_o;
  assign pc_pop       = mem_rvalid_i & (drop_cnt_q == '0) & (inflight_q != '0);
  assign rs_push      = pc_pop & ~flush_i;
  assign rs_pop       = data_valid_o & data_ready_i;

  assign data_valid_o = buffered_q != '0;
  assign data_o.pc    = resp_pc_q[rs_rd_q];
  assign data_o.line  = resp_line_q[rs_rd_q];

  always_comb begin
    pc_wr_d    = pc_push ? ptr_inc(pc_wr_q) : pc_wr_q;
    pc_rd_d    = pc_pop ? ptr_inc(pc_rd_q) : pc_rd_q;
    rs_wr_d    = rs_push ? ptr_inc(rs_wr_q) : rs_wr_q;
    rs_rd_d    = rs_pop ? ptr_inc(rs_rd_q) : rs_rd_q;
    inflight_d = inflight_q + CntW'(pc_push) - CntW'(pc_pop);
    buffered_d = buffered_q + CntW'(rs_push) - CntW'(rs_pop);
    drop_cnt_d = drop_cnt_q - CntW'(drop_hit);
    if (flush_i) begin
      pc_wr_d    = '0;
      pc_rd_d    = '0;
      rs_wr_d    = '0;
      rs_rd_d    = '0;
      inflight_d = '0;
      buffered_d = '0;
      drop_cnt_d = drop_cnt_q + inflight_q - CntW'(rvalid_known);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_wr_q    <= '0;
      pc_rd_q    <= '0;
      rs_wr_q    <= '0;
      rs_rd_q    <= '0;
      inflight_q <= '0;
      buffered_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        resp_pc_q[i]   <= '0;
        resp_line_q[i] <= '0;
      end
    end else begin
      pc_wr_q    <= pc_wr_d;
      pc_rd_q    <= pc_rd_d;
      rs_wr_q    <= rs_wr_d;
      rs_rd_q    <= rs_rd_d;
      inflight_q <= inflight_d;
      buffered_q <= buffered_d;
      drop_cnt_q <= drop_cnt_d;
      if (pc_push) pc_mem_q[pc_wr_q] <= addr_i;
      if (rs_push) begin
        resp_pc_q[rs_wr_q]   <= pc_mem_q[pc_rd_q];
        resp_line_q[rs_wr_q] <= mem_rdata_i;
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> ((inflight_q != '0) || (drop_cnt_q != '0)));
  assert property (@(posedge clk_i) disable iff (rst_i) total <= SumW'(DEPTH));

endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed bench for icache_mem_responder (DEPTH=2, LINE_W=128, XLEN=32).
module tb_icache_mem_responder;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [31:0] addr = '0, mem_addr;
  logic addr_valid = 1'b0, addr_ready, data_valid, data_ready = 1'b0;
  logic mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [127:0] mem_rdata = '0;
  len5_pkg::icache_out_t data;
  int errors = 0, checks = 0;

  localparam logic [127:0] L1 = 128'hAABB_CCDD_EEFF_0011_2233_4455_6677_88CC;
  localparam logic [127:0] LA = 128'h1111_0000_0000_0000_0000_0000_0000_00A1;
  localparam logic [127:0] LB = 128'h2222_0000_0000_0000_0000_0000_0000_00B2;
  localparam logic [127:0] LC = 128'h3333_0000_0000_0000_0000_0000_0000_00C3;
  localparam logic [127:0] LD = 128'h4444_0000_0000_0000_0000_0000_0000_00D4;

  icache_mem_responder #(.DEPTH(2), .LINE_W(128), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .addr_i(addr), .addr_valid_i(addr_valid),
    .addr_ready_o(addr_ready), .data_o(data), .data_valid_o(data_valid),
    .data_ready_i(data_ready), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr_valid = 1'b1; mem_gnt = 1'b1; addr = 32'h100;
    cyc(); cyc();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", addr_ready); end
    addr_valid = 1'b0; rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    addr = 32'h1004; addr_valid = 1'b1; mem_gnt = 1'b1; #1;
    checks++; if (mem_addr !== 32'h1000) begin errors++; $display("FAIL single_memaddr got %h want 1000", mem_addr); end
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", addr_ready); end
    cyc(); addr_valid = 1'b0;
    cyc();
    mem_rvalid = 1'b1; mem_rdata = L1; #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", data_valid); end
    cyc(); mem_rvalid = 1'b0;
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", data_valid); end
    checks++; if (data.pc !== 32'h1004) begin errors++; $display("FAIL single_pc got %h want 1004", data.pc); end
    checks++; if (data.line !== L1) begin errors++; $display("FAIL single_line got %h want %h", data.line, L1); end
    data_ready = 1'b1; cyc(); data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    data_ready = 1'b0; mem_gnt = 1'b1; addr_valid = 1'b1; addr = 32'h0; #1;
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL b2b_acc0 got %b want 1", addr_ready); end
    cyc(); addr = 32'h10; #1;
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL b2b_acc1 got %b want 1", addr_ready); end
    cyc(); addr = 32'h20; #1;
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold0 got %b want 0", addr_ready); end
    mem_rvalid = 1'b1; mem_rdata = LA; cyc();
    mem_rdata = LB; cyc(); mem_rvalid = 1'b0;
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold1 got %b want 0", addr_ready); end
    checks++; if (data.pc !== 32'h0 || data.line !== LA) begin errors++; $display("FAIL b2b_first got %h/%h want 0/%h", data.pc, data.line, LA); end
    cyc();
    checks++; if (data.pc !== 32'h0 || data_valid !== 1'b1) begin errors++; $display("FAIL b2b_stable got %h/%b want 0/1", data.pc, data_valid); end
    data_ready = 1'b1; #1;
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold2 got %b want 0", addr_ready); end
    cyc(); data_ready = 1'b0; #1;
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL b2b_acc2 got %b want 1", addr_ready); end
    checks++; if (data.pc !== 32'h10 || data.line !== LB) begin errors++; $display("FAIL b2b_second got %h/%h want 10/%h", data.pc, data.line, LB); end
    cyc(); addr_valid = 1'b0; data_ready = 1'b1;
    cyc(); data_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = LC; cyc(); mem_rvalid = 1'b0;
    checks++; if (data.pc !== 32'h20 || data.line !== LC || data_valid !== 1'b1) begin errors++; $display("FAIL b2b_third got %h/%h/%b want 20/%h/1", data.pc, data.line, data_valid, LC); end
    data_ready = 1'b1; cyc(); data_ready = 1'b0;
  endtask

  task automatic test_grant_stall();
    addr = 32'h50; addr_valid = 1'b1; mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (addr_ready !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL stall_%0d got rdy=%b req=%b want 0/1", i, addr_ready, mem_req); end
      checks++; if (dut.inflight_q !== 2'd0) begin errors++; $display("FAIL stall_pcfifo_%0d got %0d want 0", i, dut.inflight_q); end
      cyc();
    end
    mem_gnt = 1'b1; #1;
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", addr_ready); end
    cyc(); addr_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = LD; cyc(); mem_rvalid = 1'b0;
    checks++; if (data.pc !== 32'h50) begin errors++; $display("FAIL stall_pc got %h want 50", data.pc); end
    data_ready = 1'b1; cyc(); data_ready = 1'b0;
  endtask

  task automatic test_flush_two();
    mem_gnt = 1'b1; addr_valid = 1'b1; addr = 32'h60; cyc();
    addr = 32'h70; cyc(); addr_valid = 1'b0;
    flush = 1'b1; cyc(); flush = 1'b0;
    checks++; if (dut.drop_cnt_q !== 2'd2) begin errors++; $display("FAIL flush_drop2 got %0d want 2", dut.drop_cnt_q); end
    addr = 32'h40; addr_valid = 1'b1; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_nocredit got %b want 0", mem_req); end
    addr_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = LA; cyc();
    checks++; if (dut.drop_cnt_q !== 2'd1 || data_valid !== 1'b0) begin errors++; $display("FAIL flush_drop1 got %0d/%b want 1/0", dut.drop_cnt_q, data_valid); end
    mem_rdata = LB; cyc(); mem_rvalid = 1'b0;
    checks++; if (dut.drop_cnt_q !== 2'd0 || data_valid !== 1'b0) begin errors++; $display("FAIL flush_drop0 got %0d/%b want 0/0", dut.drop_cnt_q, data_valid); end
    addr_valid = 1'b1; #1;
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL flush_newacc got %b want 1", addr_ready); end
    cyc(); addr_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = LD; cyc(); mem_rvalid = 1'b0;
    checks++; if (data_valid !== 1'b1 || data.pc !== 32'h40 || data.line !== LD) begin errors++; $display("FAIL flush_newdata got %b/%h want 1/40", data_valid, data.pc); end
    data_ready = 1'b1; cyc(); data_ready = 1'b0;
  endtask

  task automatic test_flush_rvalid();
    mem_gnt = 1'b1; addr_valid = 1'b1; addr = 32'h80; cyc(); addr_valid = 1'b0;
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = LC; cyc();
    flush = 1'b0; mem_rvalid = 1'b0;
    checks++; if (dut.drop_cnt_q !== 2'd0) begin errors++; $display("FAIL flushrv_drop got %0d want 0", dut.drop_cnt_q); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL flushrv_valid got %b want 0", data_valid); end
    addr_valid = 1'b1; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flushrv_credit got %b want 1", mem_req); end
    addr_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    mem_gnt = 1'b1; addr_valid = 1'b1; addr = 32'h90; cyc();
    addr = 32'hA0; cyc(); addr_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = LA; cyc(); mem_rdata = LB; cyc(); mem_rvalid = 1'b0;
    checks++; if (data_valid !== 1'b1 || data.pc !== 32'h90) begin errors++; $display("FAIL rstmid_pre got %b/%h want 1/90", data_valid, data.pc); end
    rst = 1'b1; addr_valid = 1'b1; #1;
    checks++; if (addr_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b/%b want 0/0", addr_ready, mem_req); end
    cyc();
    checks++; if (data_valid !== 1'b0 || data !== '0) begin errors++; $display("FAIL rstmid_out got %b/%h want 0/0", data_valid, data); end
    rst = 1'b0; addr = 32'hB0; #1;
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_credit0 got %b want 1", addr_ready); end
    cyc(); addr = 32'hC0; #1;
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_credit1 got %b want 1", addr_ready); end
    cyc(); addr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_grant_stall();
    test_flush_two();
    test_flush_rvalid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
